sd_cmd_responder: RTL
=====================

# sd_cmd_responder

- Card-side end of the SD CMD line: receives 48-bit host commands, checks framing and CRC7, and hands index/argument to card logic.
- Serialises the 48-bit response (R1/R3/R6/R7 format) back onto CMD after the Ncr gap.
- Driven by the same clk_i and SD-clock strobes as the host command path.
- Used to build a synthesizable card model and loopback benches for the host controller.

## Interface
- NcrCycles, 2, minimum SD clocks between command end bit and response start bit (2..64)
- RspTimeout, 64, SD clocks to wait for card logic before abandoning the response
- clk_i  in  1  system clock
- rst_ni  in  1  asynchronous active-low reset
- clk_en_p_i  in  1  one-cycle strobe, SD clock rising edge (sample point)
- clk_en_n_i  in  1  one-cycle strobe, SD clock falling edge (drive point); never coincident with clk_en_p_i
- cmd_i  in  1  CMD line level
- cmd_o  out  1  CMD drive value
- cmd_en_o  out  1  CMD output enable
- cmd_valid_o  out  1  one-cycle pulse, good command received
- cmd_index_o  out  6  received command index, held until next command
- cmd_arg_o  out  32  received argument, held until next command
- cmd_err_o  out  1  one-cycle pulse, CRC, transmission-bit or end-bit error
- rsp_valid_i  in  1  card logic offers response
- rsp_ready_o  out  1  responder accepts response (WAIT_RSP only)
- rsp_none_i  in  1  with rsp_valid_i: command needs no response
- rsp_index_i  in  6  response index field
- rsp_arg_i  in  32  response payload
- rsp_crc_en_i  in  1  1: compute CRC7; 0: send 7'h7F (R3)
- busy_o  out  1  high in any state except IDLE

## Operation
- Reset values:
  - state IDLE; cmd_o=1, cmd_en_o=0
  - cmd_valid_o=0, cmd_err_o=0, rsp_ready_o=0, busy_o=0
  - cmd_index_o=0, cmd_arg_o=0
- IDLE:
  - on clk_en_p_i with cmd_i=0 (start bit), go RX
  - bit counter=1; CRC7 cleared, then fed the start bit
- RX: one bit shifted per clk_en_p_i, MSB first.
  - Frame layout: start 0, transmission 1, index[5:0], arg[31:0], crc[6:0], end 1.
  - CRC7 (x^7+x^3+1) covers bits 47..8.
  - After bit 0 is sampled, go CHECK.
- CHECK (one clk_i cycle):
  - Good frame (transmission=1, end=1, received CRC == computed): load cmd_index_o/cmd_arg_o, pulse cmd_valid_o, clear Ncr counter, go WAIT_RSP.
  - Otherwise: pulse cmd_err_o, go IDLE; no response, outputs unchanged.
- WAIT_RSP:
  - rsp_ready_o=1; Ncr counter increments on clk_en_p_i.
  - Handshake rsp_valid_i&rsp_ready_o with rsp_none_i=1: go IDLE.
  - Handshake with rsp_none_i=0: latch the 48-bit frame {0,0,index,arg,crc|7F,1} into the shift register, go TX_WAIT.
  - Counter reaches RspTimeout without a handshake: go IDLE silently.
- TX_WAIT: go TX on the first clk_en_n_i with Ncr counter >= NcrCycles.
  - That strobe drives the start bit: cmd_en_o=1, cmd_o=0.
- TX:
  - Each subsequent clk_en_n_i drives the next bit, MSB first.
  - The clk_en_n_i after the end bit: cmd_en_o=0, cmd_o=1, go IDLE.
- CRC for TX is computed serially as bits are driven (bits 47..8); the 7 CRC bits come from the CRC register, or 7'h7F when the latched rsp_crc_en=0.
- cmd_i is ignored in CHECK, WAIT_RSP, TX_WAIT and TX.
- rsp_valid_i outside WAIT_RSP is ignored (no ready).

## Timing
- cmd_valid_o/cmd_err_o: exactly 2 clk_i cycles after the clk_en_p_i that samples the end bit.
- Response start bit: earliest on the first clk_en_n_i after NcrCycles rising strobes following the end bit.
- Response length: exactly 48 falling strobes with cmd_en_o=1; line released on the 49th.
- Reset mid-operation: cmd_en_o drops asynchronously; frame is discarded.
- Back-to-back: a new start bit is accepted on the first clk_en_p_i after returning to IDLE.

## Structure
- Package sd_card_pkg:
  - state enum (IDLE, RX, CHECK, WAIT_RSP, TX_WAIT, TX)
  - CRC7 polynomial constant 7'h09
  - frame field offset and width localparams
- Sub-module sd_crc7_serial:
  - ports: clk_i, rst_ni, clr_i, en_i, bit_i, crc_o[6:0]
  - one instance shared between RX and TX (states are exclusive)

## Test plan
- CMD0: host frame 48'h40_0000_0000_95, rsp_none_i=1 → cmd_valid_o pulse, index 0, arg 0; cmd_en_o never asserted.
- CMD8: frame 48'h48_0000_01AA_87; reply index 8, arg 32'h1AA, crc_en=1 → line carries 48'h08_0000_01AA_13 starting 2 SD clocks after the end bit.
- Corrupted CMD0 (CRC byte 0x97) → cmd_err_o pulse, no cmd_valid_o, cmd_en_o stays 0; next good CMD0 is accepted.
- R3: reply index 6'h3F, arg 32'h80FF_8000, crc_en=0 → transmits 48'h3F_80FF_8000_FF.
- No rsp_valid_i for 64 SD clocks → busy_o falls; a following CMD8 is answered normally.
- rst_ni asserted at bit 20 of the TX frame → cmd_en_o=0, cmd_o=1 immediately; after release, IDLE and a fresh command is accepted.

Source files
------------

// File: rtl/sd_card_pkg.sv
// Shared types and constants for the card-side SD CMD responder.
package sd_card_pkg;

   typedef enum logic [2:0] {
      IDLE,
      RX,
      CHECK,
      WAIT_RSP,
      TX_WAIT,
      TX
   } sd_state_e;

   // CRC7 generator x^7 + x^3 + 1, implicit x^7 term dropped
   localparam logic [6:0] CRC7_POLY = 7'h09;

   // 48-bit CMD frame layout, bit 47 is sent first
   localparam int FRAME_W   = 48;
   localparam int START_POS = 47;
   localparam int TRANS_POS = 46;
   localparam int INDEX_LSB = 40;
   localparam int INDEX_W   = 6;
   localparam int ARG_LSB   = 8;
   localparam int ARG_W     = 32;
   localparam int CRC_LSB   = 1;
   localparam int CRC_W     = 7;
   localparam int END_POS   = 0;

   // One serial CRC7 step: shift in one message bit MSB first
   function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic data);
      logic fb;
      fb = data ^ crc[6];
      return {crc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
   endfunction

endpackage

// File: rtl/sd_crc7_serial.sv
// Bit-serial CRC7 accumulator; clear and enable together restart from a
// zero remainder with the first bit already absorbed.
module sd_crc7_serial
   import sd_card_pkg::*;
(
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       clr_i,
   input  logic       en_i,
   input  logic       bit_i,
   output logic [6:0] crc_o
);

   logic [6:0] base;

   assign base = clr_i ? 7'h00 : crc_o;

   // Remainder register: clear, absorb one bit, or hold
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         crc_o <= 7'h00;
      end else if (en_i) begin
         crc_o <= crc7_step(base, bit_i);
      end else if (clr_i) begin
         crc_o <= 7'h00;
      end
   end

endmodule

// File: rtl/sd_cmd_responder.sv
// Card-side CMD line endpoint: receives host commands, validates framing and
// CRC7, hands index/argument to card logic and serialises its response.
//
// Response handshake: a response transfers on a clk_i edge where both
// rsp_valid_i and rsp_ready_o are high; rsp_ready_o is high only while
// waiting for the card logic, and rsp_valid_i is ignored at all other times.
module sd_cmd_responder
   import sd_card_pkg::*;
#(
   parameter int NcrCycles  = 2,
   parameter int RspTimeout = 64
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        clk_en_p_i,
   input  logic        clk_en_n_i,
   input  logic        cmd_i,
   output logic        cmd_o,
   output logic        cmd_en_o,
   output logic        cmd_valid_o,
   output logic [5:0]  cmd_index_o,
   output logic [31:0] cmd_arg_o,
   output logic        cmd_err_o,
   input  logic        rsp_valid_i,
   output logic        rsp_ready_o,
   input  logic        rsp_none_i,
   input  logic [5:0]  rsp_index_i,
   input  logic [31:0] rsp_arg_i,
   input  logic        rsp_crc_en_i,
   output logic        busy_o,
   output sd_state_e   state_o
);

   localparam int NcrMax = (RspTimeout > NcrCycles) ? RspTimeout : NcrCycles;
   localparam int NcrW   = $clog2(NcrMax + 1);

   sd_state_e          state, state_next;
   logic [FRAME_W-1:0] shreg;
   logic [5:0]         bit_cnt;
   logic [NcrW-1:0]    ncr_cnt;
   logic               crc_en_lat;

   logic               crc_clr, crc_en, crc_bit;
   logic [6:0]         crc_out;
   logic               frame_ok, handshake, tx_start;
   logic [5:0]         tx_idx;
   logic               tx_bit;

   sd_crc7_serial u_crc (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .clr_i  (crc_clr),
      .en_i   (crc_en),
      .bit_i  (crc_bit),
      .crc_o  (crc_out)
   );

   assign rsp_ready_o = (state == WAIT_RSP);
   assign busy_o      = (state != IDLE);
   assign state_o     = state;
   assign handshake   = rsp_valid_i & rsp_ready_o;
   assign frame_ok    = shreg[TRANS_POS] & shreg[END_POS] &
                        (shreg[CRC_LSB +: CRC_W] == crc_out);

   // State register
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state <= IDLE;
      else         state <= state_next;
   end

   // Next state, CRC feed, and the next bit to drive while transmitting
   always_comb begin
      state_next = state;
      crc_clr    = 1'b0;
      crc_en     = 1'b0;
      crc_bit    = 1'b0;
      tx_start   = 1'b0;
      tx_idx     = bit_cnt - 6'd1;
      tx_bit     = 1'b1;
      if (tx_idx >= 6'(ARG_LSB) && tx_idx < 6'(FRAME_W)) begin
         tx_bit = shreg[tx_idx];
      end else if (tx_idx >= 6'(CRC_LSB) && tx_idx < 6'(ARG_LSB)) begin
         tx_bit = crc_en_lat ? crc_out[3'(tx_idx - 6'd1)] : 1'b1;
      end else if (tx_idx == 6'(END_POS)) begin
         tx_bit = shreg[END_POS];
      end
      case (state)
         IDLE: begin
            if (clk_en_p_i && !cmd_i) begin
               state_next = RX;
               crc_clr    = 1'b1;
               crc_en     = 1'b1;
               crc_bit    = cmd_i;
            end
         end
         RX: begin
            if (clk_en_p_i) begin
               // bit_cnt bits already taken; CRC covers frame bits 47..8
               crc_en  = (bit_cnt < 6'(FRAME_W - ARG_LSB));
               crc_bit = cmd_i;
               if (bit_cnt == 6'(FRAME_W - 1)) state_next = CHECK;
            end
         end
         CHECK: begin
            state_next = frame_ok ? WAIT_RSP : IDLE;
         end
         WAIT_RSP: begin
            if (handshake) begin
               state_next = rsp_none_i ? IDLE : TX_WAIT;
               crc_clr    = ~rsp_none_i;
            end else if (ncr_cnt == NcrW'(RspTimeout)) begin
               state_next = IDLE;
            end
         end
         TX_WAIT: begin
            if (clk_en_n_i && ncr_cnt >= NcrW'(NcrCycles)) begin
               state_next = TX;
               tx_start   = 1'b1;
               crc_en     = 1'b1;
               crc_bit    = shreg[START_POS];
            end
         end
         TX: begin
            if (clk_en_n_i) begin
               if (bit_cnt == 6'd0) begin
                  state_next = IDLE;
               end else if (tx_idx >= 6'(ARG_LSB)) begin
                  crc_en  = 1'b1;
                  crc_bit = tx_bit;
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Shift register, counters, received fields and CMD line drive
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         shreg       <= '0;
         bit_cnt     <= '0;
         ncr_cnt     <= '0;
         crc_en_lat  <= 1'b0;
         cmd_o       <= 1'b1;
         cmd_en_o    <= 1'b0;
         cmd_valid_o <= 1'b0;
         cmd_err_o   <= 1'b0;
         cmd_index_o <= '0;
         cmd_arg_o   <= '0;
      end else begin
         cmd_valid_o <= 1'b0;
         cmd_err_o   <= 1'b0;
         case (state)
            IDLE: begin
               if (clk_en_p_i && !cmd_i) begin
                  shreg   <= {shreg[FRAME_W-2:0], cmd_i};
                  bit_cnt <= 6'd1;
               end
            end
            RX: begin
               if (clk_en_p_i) begin
                  shreg   <= {shreg[FRAME_W-2:0], cmd_i};
                  bit_cnt <= bit_cnt + 6'd1;
               end
            end
            CHECK: begin
               if (frame_ok) begin
                  cmd_index_o <= shreg[INDEX_LSB +: INDEX_W];
                  cmd_arg_o   <= shreg[ARG_LSB +: ARG_W];
                  cmd_valid_o <= 1'b1;
                  ncr_cnt     <= '0;
               end else begin
                  cmd_err_o <= 1'b1;
               end
            end
            WAIT_RSP: begin
               if (clk_en_p_i && ncr_cnt < NcrW'(RspTimeout)) ncr_cnt <= ncr_cnt + 1'b1;
               if (handshake && !rsp_none_i) begin
                  // CRC field bits stored here are not driven; TX substitutes CRC or 7F
                  shreg      <= {1'b0, 1'b0, rsp_index_i, rsp_arg_i, 7'h7F, 1'b1};
                  crc_en_lat <= rsp_crc_en_i;
               end
            end
            TX_WAIT: begin
               if (clk_en_p_i && ncr_cnt < NcrW'(NcrCycles)) ncr_cnt <= ncr_cnt + 1'b1;
               if (tx_start) begin
                  cmd_en_o <= 1'b1;
                  cmd_o    <= shreg[START_POS];
                  bit_cnt  <= 6'(START_POS);
               end
            end
            TX: begin
               if (clk_en_n_i) begin
                  if (bit_cnt == 6'd0) begin
                     cmd_en_o <= 1'b0;
                     cmd_o    <= 1'b1;
                  end else begin
                     cmd_o   <= tx_bit;
                     bit_cnt <= tx_idx;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule
